mem_port_arbiter: RTL and testbench

//  Shares one single-port unified memory between instruction fetch (IF) and the MEM-stage load/store.

---
 rtl/mem_port_arbiter_if.sv | 31 +++
 rtl/mem_port_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and RAM-side signals of the unified memory port arbiter.
// The slave modport is the arbiter's view; the master modport is the pipeline/memory environment's view.
interface mem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        mem_rd;
    logic        mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_misalign;
    logic        stall;
    logic        ram_en;
    logic        ram_we;
    logic [3:0]  ram_be;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    modport slave (
        input  if_req, if_addr, mem_rd, mem_wr, mem_size, mem_addr, mem_wdata, ram_rdata,
        output if_rdata, mem_rdata, mem_misalign, stall, ram_en, ram_we, ram_be, ram_addr, ram_wdata
    );

    modport master (
        output if_req, if_addr, mem_rd, mem_wr, mem_size, mem_addr, mem_wdata, ram_rdata,
        input  if_rdata, mem_rdata, mem_misalign, stall, ram_en, ram_we, ram_be, ram_addr, ram_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port unified memory between instruction fetch and MEM-stage load/store,
// data first, and raises the pipeline stall until every request of the current step is served.
module mem_port_arbiter #(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    localparam logic [2:0] LAT_C = 3'(MEM_LAT);

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b01:   return off[0];
            2'b10:   return 1'b0;
            default: return (off != 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b01:   return 4'b0011 << off;
            2'b10:   return 4'b0001 << off;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            2'b01:   return {2{wdata[15:0]}};
            2'b10:   return {4{wdata[7:0]}};
            default: return wdata;
        endcase
    endfunction

    state_e      state_q, state_d;
    logic        owner_d_q, owner_d_d;
    logic        d_done_q, d_done_d;
    logic        i_done_q, i_done_d;
    logic        mis_q, mis_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        ram_en_q, ram_en_d;
    logic        ram_we_q, ram_we_d;
    logic [3:0]  ram_be_q, ram_be_d;
    logic [31:0] ram_addr_q, ram_addr_d;
    logic [31:0] ram_wdata_q, ram_wdata_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;

    logic        need_d_s;
    logic        need_i_s;
    logic        stall_s;
    logic        d_mis_s;
    logic        unused_s;

    assign need_d_s = bus.mem_rd | bus.mem_wr;
    assign need_i_s = bus.if_req;
    assign d_mis_s  = is_misaligned(bus.mem_size, bus.mem_addr[1:0]);
    assign stall_s  = ~rst & ((need_d_s & ~d_done_q) | (need_i_s & ~i_done_q));
    assign unused_s = ^bus.if_addr[1:0];

    // Next-state, RAM command and capture logic
    always_comb begin
        state_d     = state_q;
        owner_d_d   = owner_d_q;
        d_done_d    = d_done_q;
        i_done_d    = i_done_q;
        mis_d       = mis_q;
        cnt_d       = cnt_q;
        ram_en_d    = ram_en_q;
        ram_we_d    = ram_we_q;
        ram_be_d    = ram_be_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;

        // An advance edge retires the step; later sets in this block still win.
        if (!stall_s) begin
            d_done_d = 1'b0;
            i_done_d = 1'b0;
            mis_d    = 1'b0;
        end else begin
            d_done_d = d_done_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (need_d_s && !d_done_q) begin
                    if (d_mis_s) begin
                        mis_d    = 1'b1;
                        d_done_d = 1'b1;
                    end else begin
                        owner_d_d  = 1'b1;
                        ram_en_d   = 1'b1;
                        ram_we_d   = bus.mem_wr;
                        ram_be_d   = bus.mem_wr ? store_be(bus.mem_size, bus.mem_addr[1:0]) : 4'b1111;
                        ram_addr_d = {bus.mem_addr[31:2], 2'b00};
                        if (bus.mem_wr) begin
                            ram_wdata_d = store_lanes(bus.mem_size, bus.mem_wdata);
                        end else begin
                            ram_wdata_d = ram_wdata_q;
                        end
                        state_d    = ST_ISSUE;
                    end
                end else if (need_i_s && !i_done_q) begin
                    owner_d_d  = 1'b0;
                    ram_en_d   = 1'b1;
                    ram_we_d   = 1'b0;
                    ram_be_d   = 4'b1111;
                    ram_addr_d = {bus.if_addr[31:2], 2'b00};
                    state_d    = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                ram_en_d = 1'b0;
                ram_we_d = 1'b0;
                if (ram_we_q) begin
                    d_done_d = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    cnt_d   = LAT_C;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 3'd1) begin
                    cnt_d = 3'd0;
                    if (owner_d_q) begin
                        mem_rdata_d = bus.ram_rdata;
                        d_done_d    = 1'b1;
                    end else begin
                        if_rdata_d  = bus.ram_rdata;
                        i_done_d    = 1'b1;
                    end
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                ram_en_d = 1'b0;
                ram_we_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset cancels any access in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            owner_d_q   <= 1'b0;
            d_done_q    <= 1'b0;
            i_done_q    <= 1'b0;
            mis_q       <= 1'b0;
            cnt_q       <= 3'd0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_be_q    <= 4'd0;
            ram_addr_q  <= 32'd0;
            ram_wdata_q <= 32'd0;
            if_rdata_q  <= 32'd0;
            mem_rdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            owner_d_q   <= owner_d_d;
            d_done_q    <= d_done_d;
            i_done_q    <= i_done_d;
            mis_q       <= mis_d;
            cnt_q       <= cnt_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_be_q    <= ram_be_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    assign bus.stall        = stall_s;
    assign bus.mem_misalign = mis_q;
    assign bus.if_rdata     = if_rdata_q;
    assign bus.mem_rdata    = mem_rdata_q;
    assign bus.ram_en       = ram_en_q;
    assign bus.ram_we       = ram_we_q;
    assign bus.ram_be       = ram_be_q;
    assign bus.ram_addr     = ram_addr_q;
    assign bus.ram_wdata    = ram_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with MEM_LAT=1 (with a writable memory model)
// and one with MEM_LAT=3 (read-only), each with an access log recorded on every ram_en cycle.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if bus1 ();
    mem_port_arbiter_if bus3 ();

    mem_port_arbiter #(.MEM_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    mem_port_arbiter #(.MEM_LAT(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } acc_t;

    acc_t log1[$];
    acc_t log3[$];

    bit   [31:0] mem1 [0:255];
    bit          wv1  [0:255];
    logic [31:0] rd1_q;
    logic [31:0] p0_q, p1_q, p2_q;

    function automatic logic [31:0] rom(input logic [31:0] a);
        case (a)
            32'h0000_0040: return 32'h8C01_0004;
            32'h0000_0060: return 32'hCAFE_F00D;
            32'h0000_0100: return 32'h1122_3344;
            32'h0000_0008: return 32'h5566_7788;
            default:       return 32'h0000_0000;
        endcase
    endfunction

    function automatic logic [31:0] word1(input logic [31:0] a);
        return wv1[a[9:2]] ? mem1[a[9:2]] : rom({a[31:2], 2'b00});
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        end
        return r;
    endfunction

    // Memory model, latency 1, plus access log
    always @(posedge clk) begin
        if (bus1.ram_en === 1'b1 && bus1.ram_we === 1'b1) begin
            mem1[bus1.ram_addr[9:2]] <= merge(word1(bus1.ram_addr), bus1.ram_wdata, bus1.ram_be);
            wv1[bus1.ram_addr[9:2]]  <= 1'b1;
        end
        if (bus1.ram_en === 1'b1 && bus1.ram_we === 1'b0) rd1_q <= word1(bus1.ram_addr);
        else rd1_q <= 32'hDEAD_BEEF;
        if (bus1.ram_en === 1'b1) log1.push_back(acc_t'{bus1.ram_addr, bus1.ram_we, bus1.ram_be, bus1.ram_wdata});
    end

    // Memory model, latency 3 (read only), plus access log
    always @(posedge clk) begin
        if (bus3.ram_en === 1'b1 && bus3.ram_we === 1'b0) p0_q <= rom(bus3.ram_addr);
        else p0_q <= 32'hDEAD_BEEF;
        p1_q <= p0_q;
        p2_q <= p1_q;
        if (bus3.ram_en === 1'b1) log3.push_back(acc_t'{bus3.ram_addr, bus3.ram_we, bus3.ram_be, bus3.ram_wdata});
    end

    assign bus1.ram_rdata = rd1_q;
    assign bus3.ram_rdata = p2_q;

    task automatic idle1();
        bus1.if_req = 1'b0; bus1.if_addr = 32'h0; bus1.mem_rd = 1'b0; bus1.mem_wr = 1'b0;
        bus1.mem_size = 2'b00; bus1.mem_addr = 32'h0; bus1.mem_wdata = 32'h0;
    endtask

    task automatic idle3();
        bus3.if_req = 1'b0; bus3.if_addr = 32'h0; bus3.mem_rd = 1'b0; bus3.mem_wr = 1'b0;
        bus3.mem_size = 2'b00; bus3.mem_addr = 32'h0; bus3.mem_wdata = 32'h0;
    endtask

    // Counts stalled cycles from the current (just-driven) cycle until stall drops; bounded.
    task automatic meas1(output int n);
        n = 0;
        #1;
        while (bus1.stall === 1'b1 && n < 40) begin
            n++;
            @(negedge clk); #1;
        end
    endtask

    task automatic meas3(output int n);
        n = 0;
        #1;
        while (bus3.stall === 1'b1 && n < 40) begin
            n++;
            @(negedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle1(); idle3();
        @(negedge clk);
        bus1.if_req = 1'b1;
        #1;
        checks++; if (bus1.stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", bus1.stall); end
        checks++; if (bus1.ram_en !== 1'b0 || bus1.ram_we !== 1'b0) begin errors++; $display("FAIL reset_en_we: got %b%b want 00", bus1.ram_en, bus1.ram_we); end
        checks++; if (bus1.ram_be !== 4'h0) begin errors++; $display("FAIL reset_be: got %h want 0", bus1.ram_be); end
        checks++; if (bus1.ram_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", bus1.ram_addr); end
        checks++; if (bus1.ram_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h want 0", bus1.ram_wdata); end
        checks++; if (bus1.if_rdata !== 32'h0) begin errors++; $display("FAIL reset_if_rdata: got %h want 0", bus1.if_rdata); end
        checks++; if (bus1.mem_rdata !== 32'h0) begin errors++; $display("FAIL reset_mem_rdata: got %h want 0", bus1.mem_rdata); end
        checks++; if (bus1.mem_misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign: got %b want 0", bus1.mem_misalign); end
        bus1.if_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk); #1;
        checks++; if (bus1.stall !== 1'b0 || bus3.stall !== 1'b0) begin errors++; $display("FAIL idle_stall: got %b%b want 00", bus1.stall, bus3.stall); end
    endtask

    task automatic test_fetch();
        int n;
        log1.delete();
        @(negedge clk);
        bus1.if_req = 1'b1; bus1.if_addr = 32'h40;
        meas1(n);
        checks++; if (n !== 3) begin errors++; $display("FAIL fetch_stall_cycles: got %0d want 3", n); end
        checks++; if (bus1.if_rdata !== 32'h8C01_0004) begin errors++; $display("FAIL fetch_rdata: got %h want 8c010004", bus1.if_rdata); end
        checks++; if (log1.size() !== 1) begin errors++; $display("FAIL fetch_access_count: got %0d want 1", log1.size()); end
        else begin
            checks++; if (log1[0].addr !== 32'h40 || log1[0].we !== 1'b0 || log1[0].be !== 4'hF) begin errors++; $display("FAIL fetch_access: got %h/%b/%b want 00000040/0/1111", log1[0].addr, log1[0].we, log1[0].be); end
        end
        @(negedge clk); idle1(); #1;
        checks++; if (bus1.stall !== 1'b0 || bus1.if_rdata !== 32'h8C01_0004) begin errors++; $display("FAIL fetch_hold: got %b/%h want 0/8c010004", bus1.stall, bus1.if_rdata); end
    endtask

    task automatic test_store_byte_then_fetch();
        int n;
        log1.delete();
        @(negedge clk);
        bus1.mem_wr = 1'b1; bus1.mem_size = 2'b10; bus1.mem_addr = 32'h13; bus1.mem_wdata = 32'h0000_00AB;
        bus1.if_req = 1'b1; bus1.if_addr = 32'h60;
        meas1(n);
        checks++; if (n !== 5) begin errors++; $display("FAIL sb_fetch_stall_cycles: got %0d want 5", n); end
        checks++; if (log1.size() !== 2) begin errors++; $display("FAIL sb_fetch_access_count: got %0d want 2", log1.size()); end
        else begin
            checks++; if (log1[0] !== acc_t'{32'h10, 1'b1, 4'b1000, 32'hABAB_ABAB}) begin errors++; $display("FAIL sb_access: got %h want 00000010/1/8/ababab", log1[0]); end
            checks++; if (log1[1].addr !== 32'h60 || log1[1].we !== 1'b0) begin errors++; $display("FAIL sb_then_fetch: got %h/%b want 00000060/0", log1[1].addr, log1[1].we); end
        end
        checks++; if (bus1.if_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL sb_fetch_rdata: got %h want cafef00d", bus1.if_rdata); end
        checks++; if (word1(32'h10) !== 32'hAB00_0000) begin errors++; $display("FAIL sb_mem_content: got %h want ab000000", word1(32'h10)); end
        @(negedge clk); idle1();
    endtask

    task automatic test_misalign();
        int n;
        log1.delete();
        @(negedge clk);
        bus1.mem_rd = 1'b1; bus1.mem_size = 2'b01; bus1.mem_addr = 32'h21;
        meas1(n);
        checks++; if (n !== 1) begin errors++; $display("FAIL mis_stall_cycles: got %0d want 1", n); end
        checks++; if (bus1.mem_misalign !== 1'b1) begin errors++; $display("FAIL mis_flag: got %b want 1", bus1.mem_misalign); end
        checks++; if (log1.size() !== 0) begin errors++; $display("FAIL mis_no_access: got %0d want 0", log1.size()); end
        checks++; if (bus1.mem_rdata !== 32'h0) begin errors++; $display("FAIL mis_rdata_hold: got %h want 0", bus1.mem_rdata); end
        @(negedge clk); idle1(); #1;
        checks++; if (bus1.mem_misalign !== 1'b0) begin errors++; $display("FAIL mis_flag_clear: got %b want 0", bus1.mem_misalign); end
    endtask

    task automatic test_load_fetch_lat3();
        int n;
        log3.delete();
        @(negedge clk);
        bus3.mem_rd = 1'b1; bus3.mem_size = 2'b00; bus3.mem_addr = 32'h100;
        bus3.if_req = 1'b1; bus3.if_addr = 32'h8;
        meas3(n);
        checks++; if (n !== 10) begin errors++; $display("FAIL lat3_stall_cycles: got %0d want 10", n); end
        checks++; if (log3.size() !== 2) begin errors++; $display("FAIL lat3_access_count: got %0d want 2", log3.size()); end
        else begin
            checks++; if (log3[0].addr !== 32'h100 || log3[1].addr !== 32'h8) begin errors++; $display("FAIL lat3_order: got %h,%h want 00000100,00000008", log3[0].addr, log3[1].addr); end
            checks++; if (log3[0].we !== 1'b0 || log3[0].be !== 4'hF) begin errors++; $display("FAIL lat3_load_strobes: got %b/%b want 0/1111", log3[0].we, log3[0].be); end
        end
        checks++; if (bus3.mem_rdata !== 32'h1122_3344) begin errors++; $display("FAIL lat3_mem_rdata: got %h want 11223344", bus3.mem_rdata); end
        checks++; if (bus3.if_rdata !== 32'h5566_7788) begin errors++; $display("FAIL lat3_if_rdata: got %h want 55667788", bus3.if_rdata); end
        @(negedge clk); idle3();
    endtask

    task automatic test_reset_mid_wait();
        int n;
        log1.delete();
        @(negedge clk);
        bus1.mem_rd = 1'b1; bus1.mem_size = 2'b00; bus1.mem_addr = 32'h60;
        @(negedge clk); #1;
        checks++; if (bus1.ram_en !== 1'b1) begin errors++; $display("FAIL rstw_issue: got %b want 1", bus1.ram_en); end
        @(negedge clk);
        rst = 1'b1; #1;
        checks++; if (bus1.ram_en !== 1'b0 || bus1.stall !== 1'b0) begin errors++; $display("FAIL rstw_cancel: got en=%b stall=%b want 0 0", bus1.ram_en, bus1.stall); end
        @(negedge clk);
        rst = 1'b0;
        meas1(n);
        checks++; if (n !== 3) begin errors++; $display("FAIL rstw_restart_cycles: got %0d want 3", n); end
        checks++; if (bus1.mem_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL rstw_rdata: got %h want cafef00d", bus1.mem_rdata); end
        checks++; if (log1.size() !== 2) begin errors++; $display("FAIL rstw_access_count: got %0d want 2", log1.size()); end
        else begin
            checks++; if (log1[1].addr !== 32'h60) begin errors++; $display("FAIL rstw_restart_addr: got %h want 00000060", log1[1].addr); end
        end
        @(negedge clk); idle1();
    endtask

    task automatic test_back_to_back();
        int n;
        log1.delete();
        @(negedge clk);
        bus1.mem_wr = 1'b1; bus1.mem_size = 2'b01; bus1.mem_addr = 32'h2; bus1.mem_wdata = 32'h0000_BEEF;
        meas1(n);
        checks++; if (n !== 2) begin errors++; $display("FAIL b2b_step1_cycles: got %0d want 2", n); end
        @(negedge clk);
        bus1.mem_wdata = 32'h0000_1234;
        meas1(n);
        checks++; if (n !== 2) begin errors++; $display("FAIL b2b_step2_cycles: got %0d want 2", n); end
        @(negedge clk); idle1(); #1;
        checks++; if (bus1.stall !== 1'b0) begin errors++; $display("FAIL b2b_idle_stall: got %b want 0", bus1.stall); end
        @(negedge clk); @(negedge clk);
        checks++; if (log1.size() !== 2) begin errors++; $display("FAIL b2b_access_count: got %0d want 2", log1.size()); end
        else begin
            checks++; if (log1[0] !== acc_t'{32'h0, 1'b1, 4'b1100, 32'hBEEF_BEEF}) begin errors++; $display("FAIL b2b_step1_access: got %h want 00000000/1/c/beefbeef", log1[0]); end
            checks++; if (log1[1] !== acc_t'{32'h0, 1'b1, 4'b1100, 32'h1234_1234}) begin errors++; $display("FAIL b2b_step2_access: got %h want 00000000/1/c/12341234", log1[1]); end
        end
        checks++; if (word1(32'h0) !== 32'h1234_0000) begin errors++; $display("FAIL b2b_mem_content: got %h want 12340000", word1(32'h0)); end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store_byte_then_fetch();
        test_misalign();
        test_load_fetch_lat3();
        test_reset_mid_wait();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
